// File: rtl/nrisc_ula_pkg.sv
// Shared definitions for the NRISC ULA command sequencer: opcodes, flag
// bit positions, sequencer state encoding and opcode classification helpers.
package nrisc_ula_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SHR = 4'b0101;
    localparam logic [3:0] OP_RTR = 4'b1101;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_RTL = 4'b1110;
    localparam logic [3:0] OP_NOT = 4'b0111;

    localparam int FLAG_NEG   = 2;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_CARRY = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic logic is_shift(input logic [3:0] op);
        logic r;
        case (op)
            OP_SHR, OP_RTR, OP_SHL, OP_RTL: r = 1'b1;
            default:                        r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_valid_op(input logic [3:0] op);
        logic r;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_SHR, OP_RTR, OP_SHL, OP_RTL, OP_NOT: r = 1'b1;
            default:                                r = 1'b0;
        endcase
        return r;
    endfunction

    // Flags of a pass-through value: only the zero bit can be set.
    function automatic logic [2:0] zero_only_flags(input logic is_zero);
        logic [2:0] f;
        f             = 3'b000;
        f[FLAG_NEG]   = 1'b0;
        f[FLAG_ZERO]  = is_zero;
        f[FLAG_CARRY] = 1'b0;
        return f;
    endfunction

endpackage

// File: rtl/nrisc_ula_seq_if.sv
// Bundle of the command, ULA-drive and result channels of the sequencer.
// slave = the sequencer itself, master = decode/ULA/consumer environment.
interface nrisc_ula_seq_if #(
    parameter int TAM  = 16,
    parameter int CNTW = 4
) ();
    logic            cmd_valid;
    logic            cmd_ready;
    logic [3:0]      cmd_op;
    logic            cmd_incdec;
    logic [CNTW-1:0] cmd_cnt;
    logic [TAM-1:0]  cmd_a;
    logic [TAM-1:0]  cmd_b;

    logic [TAM-1:0]  ula_a;
    logic [TAM-1:0]  ula_b;
    logic [3:0]      ula_ctrl;
    logic            ula_incdec;
    logic [TAM-1:0]  ula_out;
    logic [2:0]      ula_flags;

    logic            res_valid;
    logic            res_ready;
    logic [TAM-1:0]  res_data;
    logic [2:0]      res_flags;
    logic            res_err;
    logic [2:0]      flag_q;

    modport slave (
        input  cmd_valid, cmd_op, cmd_incdec, cmd_cnt, cmd_a, cmd_b,
        output cmd_ready,
        output ula_a, ula_b, ula_ctrl, ula_incdec,
        input  ula_out, ula_flags,
        output res_valid, res_data, res_flags, res_err, flag_q,
        input  res_ready
    );

    modport master (
        output cmd_valid, cmd_op, cmd_incdec, cmd_cnt, cmd_a, cmd_b,
        input  cmd_ready,
        input  ula_a, ula_b, ula_ctrl, ula_incdec,
        output ula_out, ula_flags,
        input  res_valid, res_data, res_flags, res_err, flag_q,
        output res_ready
    );
endinterface

// File: rtl/nrisc_ula_seq.sv
// Command-side sequencer for the NRISC ULA: registers ULA inputs, iterates
// multi-bit shifts/rotates one bit per cycle, and returns results with flags.
module nrisc_ula_seq
    import nrisc_ula_pkg::*;
#(
    parameter int TAM  = 16,
    parameter int CNTW = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    nrisc_ula_seq_if.slave  bus
);

    localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
    localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};
    localparam logic [TAM-1:0]  TAM_ONE  = {{(TAM-1){1'b0}}, 1'b1};

    state_t          r_state;
    logic [TAM-1:0]  r_ula_a;
    logic [TAM-1:0]  r_ula_b;
    logic [3:0]      r_ula_ctrl;
    logic            r_ula_incdec;
    logic [CNTW-1:0] r_cnt;
    logic            r_res_valid;
    logic [TAM-1:0]  r_res_data;
    logic [2:0]      r_res_flags;
    logic            r_res_err;
    logic [2:0]      r_flag_q;

    logic w_cmd_ready;
    logic w_accept;
    logic w_op_valid;
    logic w_op_shift;
    logic w_use_incdec;
    logic w_cnt_zero;

    // Command decode; ready depends on live reset so it drops inside reset.
    always_comb begin
        w_cmd_ready  = (r_state == ST_IDLE) && i_rst;
        w_accept     = bus.cmd_valid && w_cmd_ready;
        w_op_valid   = is_valid_op(bus.cmd_op);
        w_op_shift   = is_shift(bus.cmd_op);
        w_use_incdec = bus.cmd_incdec &&
                       ((bus.cmd_op == OP_ADD) || (bus.cmd_op == OP_SUB));
        w_cnt_zero   = (bus.cmd_cnt == CNT_ZERO);
    end

    // Sequencer FSM with all registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state      <= ST_IDLE;
            r_ula_a      <= '0;
            r_ula_b      <= '0;
            r_ula_ctrl   <= 4'b0000;
            r_ula_incdec <= 1'b0;
            r_cnt        <= CNT_ZERO;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_res_flags  <= 3'b000;
            r_res_err    <= 1'b0;
            r_flag_q     <= 3'b000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (!w_op_valid) begin
                            r_res_data  <= '0;
                            r_res_flags <= 3'b000;
                            r_res_err   <= 1'b1;
                            r_res_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else if (w_op_shift && w_cnt_zero) begin
                            // Zero-length shift bypasses the ULA entirely.
                            r_res_data  <= bus.cmd_a;
                            r_res_flags <= zero_only_flags(bus.cmd_a == '0);
                            r_res_err   <= 1'b0;
                            r_res_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_ula_a    <= bus.cmd_a;
                            r_ula_ctrl <= bus.cmd_op;
                            if (w_use_incdec) begin
                                r_ula_b      <= TAM_ONE;
                                r_ula_incdec <= 1'b1;
                            end else begin
                                r_ula_b      <= bus.cmd_b;
                                r_ula_incdec <= 1'b0;
                            end
                            r_cnt     <= w_op_shift ? bus.cmd_cnt : CNT_ONE;
                            r_res_err <= 1'b0;
                            r_state   <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    r_res_data  <= bus.ula_out;
                    r_res_flags <= bus.ula_flags;
                    r_cnt       <= r_cnt - CNT_ONE;
                    if (r_cnt > CNT_ONE) begin
                        // Feed the partial result back for the next single-bit step.
                        r_ula_a <= bus.ula_out;
                    end else begin
                        r_flag_q    <= bus.ula_flags;
                        r_res_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_res_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = w_cmd_ready;
    assign bus.ula_a      = r_ula_a;
    assign bus.ula_b      = r_ula_b;
    assign bus.ula_ctrl   = r_ula_ctrl;
    assign bus.ula_incdec = r_ula_incdec;
    assign bus.res_valid  = r_res_valid;
    assign bus.res_data   = r_res_data;
    assign bus.res_flags  = r_res_flags;
    assign bus.res_err    = r_res_err;
    assign bus.flag_q     = r_flag_q;

endmodule

// File: tb/tb_nrisc_ula_seq.sv
// Self-checking bench for nrisc_ula_seq with a behavioural single-step ULA
// attached and a whole-command reference model computed arithmetically.
module tb_nrisc_ula_seq;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    logic [2:0] exp_flagq;

    nrisc_ula_seq_if #(.TAM(16), .CNTW(4)) bus ();

    nrisc_ula_seq #(.TAM(16), .CNTW(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One ULA step: returns {neg, zero, carry, result}.
    function automatic logic [18:0] ula_step(input logic [15:0] a, input logic [15:0] b,
                                             input logic [3:0] c, input logic inc);
        logic [16:0] t;
        logic [15:0] r;
        logic        cy;
        t = 17'd0; r = 16'h0000; cy = 1'b0;
        case (c)
            4'b0000: begin t = {1'b0, a} + {1'b0, (inc ? 16'd1 : b)}; r = t[15:0]; cy = t[16]; end
            4'b0001: begin t = {1'b0, a} - {1'b0, (inc ? 16'd1 : b)}; r = t[15:0]; cy = t[16]; end
            4'b0010: r = a & b;
            4'b0011: r = a | b;
            4'b0100: r = a ^ b;
            4'b0101: begin r = a >> 1; cy = a[0]; end
            4'b1101: begin r = {a[0], a[15:1]}; cy = a[0]; end
            4'b0110: begin r = a << 1; cy = a[15]; end
            4'b1110: begin r = {a[14:0], a[15]}; cy = a[15]; end
            4'b0111: r = ~a;
            default: r = 16'h0000;
        endcase
        return {r[15], (r == 16'h0000), cy, r};
    endfunction

    always_comb begin
        {bus.ula_flags, bus.ula_out} = ula_step(bus.ula_a, bus.ula_b, bus.ula_ctrl, bus.ula_incdec);
    end

    function automatic bit m_is_shift(input logic [3:0] op);
        return (op == 4'b0101) || (op == 4'b1101) || (op == 4'b0110) || (op == 4'b1110);
    endfunction

    function automatic bit m_is_valid(input logic [3:0] op);
        return (op[3] == 1'b0) || (op == 4'b1101) || (op == 4'b1110);
    endfunction

    // k-bit shift/rotate done in one go: returns {carry_of_last_step, result}.
    function automatic logic [16:0] ref_shift(input logic [3:0] op, input logic [15:0] a, input int k);
        logic [31:0] w;
        logic [15:0] d;
        logic        c;
        w = 32'h0; d = a; c = 1'b0;
        case (op)
            4'b0110: begin w = {16'h0000, a} << k; d = w[15:0];  c = w[16]; end
            4'b0101: begin w = {a, 16'h0000} >> k; d = w[31:16]; c = w[15]; end
            4'b1110: begin w = {a, a} << k;        d = w[31:16]; c = d[0];  end
            4'b1101: begin w = {a, a} >> k;        d = w[15:0];  c = d[15]; end
            default: begin d = a; c = 1'b0; end
        endcase
        return {c, d};
    endfunction

    // Whole command: returns {err, neg, zero, carry, data}.
    function automatic logic [19:0] ref_cmd(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic inc, input int cnt);
        logic [16:0] s;
        logic [15:0] bb;
        logic [15:0] d;
        logic        c;
        bb = (inc && (op == 4'b0000 || op == 4'b0001)) ? 16'd1 : b;
        c = 1'b0; d = 16'h0000; s = 17'd0;
        if (!m_is_valid(op)) return 20'h80000;
        if (m_is_shift(op)) begin
            if (cnt == 0) return {1'b0, 1'b0, (a == 16'h0000), 1'b0, a};
            s = ref_shift(op, a, cnt);
            d = s[15:0]; c = s[16];
        end else if (op == 4'b0000) begin
            s = a + bb; d = s[15:0]; c = s[16];
        end else if (op == 4'b0001) begin
            s = {1'b0, a} - {1'b0, bb}; d = s[15:0]; c = s[16];
        end else if (op == 4'b0010) d = a & b;
        else if (op == 4'b0011) d = a | b;
        else if (op == 4'b0100) d = a ^ b;
        else d = ~a;
        return {1'b0, d[15], (d == 16'h0000), c, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic inc, input logic [3:0] cnt, input int hold, input bit early);
        logic [19:0] exp;
        logic [16:0] part;
        logic [3:0]  prev_ctrl;
        bit          uses_ula;
        int          exp_lat;
        int          lat;
        exp      = ref_cmd(op, a, b, inc, int'(cnt));
        uses_ula = m_is_valid(op) && !(m_is_shift(op) && cnt == 4'd0);
        exp_lat  = !uses_ula ? 0 : (m_is_shift(op) ? int'(cnt) : 1);
        for (int i = 0; i < 10 && bus.cmd_ready !== 1'b1; i++) @(negedge clk);
        chk("cmd_ready_idle", {31'd0, bus.cmd_ready}, 32'd1);
        prev_ctrl      = bus.ula_ctrl;
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = op;
        bus.cmd_a      = a;
        bus.cmd_b      = b;
        bus.cmd_incdec = inc;
        bus.cmd_cnt    = cnt;
        bus.res_ready  = early;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        lat = 0;
        for (int j = 0; j < 40; j++) begin
            if (bus.res_valid === 1'b1) break;
            if (uses_ula) begin
                chk("ula_ctrl", {28'd0, bus.ula_ctrl}, {28'd0, op});
                if (m_is_shift(op)) begin
                    part = ref_shift(op, a, j);
                    chk("ula_a_step", {16'd0, bus.ula_a}, {16'd0, part[15:0]});
                end else begin
                    chk("ula_a", {16'd0, bus.ula_a}, {16'd0, a});
                    chk("ula_b", {16'd0, bus.ula_b},
                        {16'd0, (inc && op[3:1] == 3'b000) ? 16'd1 : b});
                    chk("ula_incdec", {31'd0, bus.ula_incdec}, {31'd0, inc && op[3:1] == 3'b000});
                end
            end
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, exp_lat);
        if (uses_ula) exp_flagq = exp[18:16];
        if (!uses_ula && m_is_valid(op))
            chk("ula_ctrl_kept", {28'd0, bus.ula_ctrl}, {28'd0, prev_ctrl});
        for (int h = 0; h <= (early ? 0 : hold); h++) begin
            chk("res_data", {16'd0, bus.res_data}, {16'd0, exp[15:0]});
            chk("res_flags", {29'd0, bus.res_flags}, {29'd0, exp[18:16]});
            chk("res_err", {31'd0, bus.res_err}, {31'd0, exp[19]});
            chk("flag_q", {29'd0, bus.flag_q}, {29'd0, exp_flagq});
            chk("cmd_ready_done", {31'd0, bus.cmd_ready}, 32'd0);
            chk("res_valid_hold", {31'd0, bus.res_valid}, 32'd1);
            if (h < hold && !early) @(negedge clk);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk("res_valid_clr", {31'd0, bus.res_valid}, 32'd0);
        chk("res_err_keep", {31'd0, bus.res_err}, {31'd0, exp[19]});
        chk("cmd_ready_back", {31'd0, bus.cmd_ready}, 32'd1);
    endtask

    initial begin
        logic [15:0] ra;
        n_cmp = 0; n_fail = 0; exp_flagq = 3'b000;
        rst = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = 4'b0000; bus.cmd_incdec = 1'b0;
        bus.cmd_cnt = 4'd0; bus.cmd_a = 16'h0000; bus.cmd_b = 16'h0000; bus.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        chk("rst_ula", {bus.ula_a, bus.ula_b[10:0], bus.ula_ctrl, bus.ula_incdec}, 32'd0);
        chk("rst_res", {bus.res_data, 9'd0, bus.res_valid, bus.res_flags, bus.res_err, bus.flag_q}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        run_cmd(4'b0000, 16'h7FFF, 16'h0001, 1'b0, 4'd0, 0, 1'b0);
        run_cmd(4'b0001, 16'h0005, 16'hFFFF, 1'b1, 4'd0, 0, 1'b0);
        run_cmd(4'b0110, 16'h0123, 16'h0000, 1'b0, 4'd4, 0, 1'b0);
        run_cmd(4'b1101, 16'h00A5, 16'h0000, 1'b0, 4'd0, 0, 1'b0);
        run_cmd(4'b1010, 16'h1234, 16'h5678, 1'b0, 4'd3, 0, 1'b0);
        run_cmd(4'b0010, 16'hF0F0, 16'h0FF0, 1'b0, 4'd0, 3, 1'b0);
        run_cmd(4'b0101, 16'h8001, 16'h0000, 1'b0, 4'd15, 0, 1'b1);
        run_cmd(4'b0110, 16'h0000, 16'h0000, 1'b0, 4'd0, 1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            run_cmd(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    $urandom_range(0, 2), bit'($urandom_range(0, 1)));
        end

        // Reset in the middle of an 8-step shift drops the command.
        ra = 16'($urandom) | 16'h0001;
        for (int i = 0; i < 10 && bus.cmd_ready !== 1'b1; i++) @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = 4'b0110; bus.cmd_a = ra;
        bus.cmd_cnt = 4'd8; bus.cmd_incdec = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_exec_busy", {31'd0, bus.res_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        chk("rst2_ula", {bus.ula_a, bus.ula_b[10:0], bus.ula_ctrl, bus.ula_incdec}, 32'd0);
        chk("rst2_res", {bus.res_data, 9'd0, bus.res_valid, bus.res_flags, bus.res_err, bus.flag_q}, 32'd0);
        rst = 1'b1;
        exp_flagq = 3'b000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_res_after_rst", {31'd0, bus.res_valid}, 32'd0);
        end
        chk("cmd_ready_after_rst", {31'd0, bus.cmd_ready}, 32'd1);
        run_cmd(4'b1110, 16'h8421, 16'h0000, 1'b0, 4'd5, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/nrisc_ula_seq.md
# nrisc_ula_seq

Command-side sequencer for the NRISC ULA. Accepts ALU commands over a valid/ready handshake, drives the combinational `NRISC_ULA` operand, control and `incdec` inputs from registers, and captures `ULA_OUT` and `ULA_flags`. Multi-bit shifts and rotates are executed as repeated single-bit ULA steps. Results are returned over a second valid/ready handshake, and a persistent flag register is updated. The block sits between instruction decode and the ULA.

## Interface
- `TAM`, 16: datapath width; must match the ULA's `TAM`.
- `CNTW`, 4: shift/rotate count width; 0 to 2^CNTW-1 steps.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous reset, active low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high only in IDLE while `rst`=1.
- `cmd_op`  in  4  ULA_ctrl encoding: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SHR, 1101 RTR, 0110 SHL, 1110 RTL, 0111 NOT.
- `cmd_incdec`  in  1  increment/decrement; honoured only for ADD and SUB.
- `cmd_cnt`  in  CNTW  step count; used only for SHR, RTR, SHL and RTL.
- `cmd_a`, `cmd_b`  in  TAM  operands.
- `ula_a`, `ula_b`  out  TAM  registered, to ULA_A/ULA_B.
- `ula_ctrl`  out  4  registered, to ULA_ctrl.
- `ula_incdec`  out  1  registered, to the ULA's incdec.
- `ula_out`  in  TAM  from ULA_OUT.
- `ula_flags`  in  3  from ULA_flags, ordered {neg, zero, carry}.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumed.
- `res_data`  out  TAM  result.
- `res_flags`  out  3  flags of the result.
- `res_err`  out  1  unsupported opcode.
- `flag_q`  out  3  persistent flag register.

## Operation
- The state machine has three states: IDLE, EXEC and DONE.
- Accept: at a `clk` edge with `cmd_valid` & `cmd_ready`, latch `ula_a`=`cmd_a` and `ula_ctrl`=`cmd_op`.
- If `cmd_incdec`=1 and the op is ADD or SUB: drive `ula_b`=1 and `ula_incdec`=1.
- Otherwise: drive `ula_b`=`cmd_b` and `ula_incdec`=0.
- Step counter:
  - Shift/rotate ops: loaded with `cmd_cnt`.
  - All other valid ops: loaded with 1.
- Next state after accept:
  - Valid op with count ≥1: EXEC.
  - Shift/rotate with count 0: DONE, with `res_data`=`cmd_a`, `res_flags`={0, `cmd_a`==0, 0}. The ULA is not used.
  - Unsupported op (1000, 1001, 1010, 1011, 1100, 1111): DONE, with `res_data`=0, `res_flags`=000, `res_err`=1. `flag_q` is unchanged.
- EXEC, on each edge:
  - Capture `ula_out` into `res_data` and `ula_flags` into `res_flags`, and decrement the counter.
  - If the counter was >1: set `ula_a` ← `ula_out` and stay in EXEC. This is the iterative shift.
  - If the counter was 1: go to DONE and set `flag_q` ← `ula_flags`.
- DONE: `res_valid`=1. `res_data`, `res_flags` and `res_err` hold stable until `res_ready`=1, then go to IDLE.
- `res_err` clears on the next accept.
- The ULA inputs keep their last values while in IDLE and DONE.

## Timing
- Reset (`rst`=0 at an edge) forces the following, including mid-EXEC or mid-DONE, where the command is dropped and no result is produced:
  - state IDLE;
  - `ula_a`=0, `ula_b`=0, `ula_ctrl`=0000, `ula_incdec`=0;
  - `res_valid`=0, `res_data`=0, `res_flags`=000, `res_err`=0, `flag_q`=000;
  - `cmd_ready`=0 while `rst`=0.
- Latency, with accept at edge E0:
  - Single-step op: `res_valid` is high after edge E1.
  - Shift/rotate with count k≥1: high after edge Ek.
  - Count-0 shift/rotate and unsupported ops: high after edge E0.
- Throughput: IDLE needs one cycle between commands. There is no accept in the cycle in which DONE is left.
- `res_ready` is allowed high before `res_valid`. DONE→IDLE occurs on the first edge at which both are high.
- Per-step rules:
  - The ULA result is sampled exactly one cycle after its inputs change.
  - The carry and neg of a multi-step shift are those of the last step.
- The counter never wraps: it only decrements while in EXEC, starting from a value ≥1.

## Structure
- Package `nrisc_ula_pkg`:
  - the opcode constants above;
  - flag bit indices (FLAG_NEG=2, FLAG_ZERO=1, FLAG_CARRY=0);
  - the state typedef;
  - the functions `is_shift(op)` and `is_valid_op(op)`.
- The block is a single module with no sub-module. The ULA itself is instantiated by the parent alongside `nrisc_ula_seq`.

## Test plan
All scenarios use TAM=16, with the real `NRISC_ULA` attached.
- ADD 0x7FFF + 0x0001, incdec=0 → `res_data`=0x8000 after E1; `res_flags` and `flag_q` equal the ULA's flags for that step.
- SUB with A=0x0005, B=0xFFFF, incdec=1 → `ula_b`=0x0001 and `ula_incdec`=1 observed; `res_data`=0x0004.
- SHL with cnt=4, A=0x0123 → `ula_ctrl`=0110 for 4 cycles, `ula_a` sequence 0x0123, 0x0246, 0x048C, 0x0918; `res_data`=0x1230 after E4.
- RTR with cnt=0, A=0x00A5 → `res_data`=0x00A5 and `res_flags`=000 after E0; `ula_ctrl` unchanged.
- Opcode 1010 → `res_err`=1, `res_data`=0, `flag_q` unchanged; the next valid command clears `res_err`.
- Backpressure and reset:
  - `res_ready` low for 3 cycles → outputs stable and `cmd_ready`=0 throughout.
  - Reset asserted during SHL cnt=8 at step 3 → all outputs at reset values the next cycle; no `res_valid`.
